// File: rtl/wf_pkg.sv
// Shared types and constants for the wall-following controller.
package wf_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEEK        = 3'd1,
        FOLLOW      = 3'd2,
        TURN_AWAY   = 3'd3,
        TURN_TOWARD = 3'd4,
        HALT        = 3'd5
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/sensor_debounce.sv
// Single-sensor debouncer: clean follows raw only after a run of stable samples.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Count disagreeing samples; flip clean on the edge the run reaches its length
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (raw == clean) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            clean <= raw;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/wall_follower_ctrl.sv
// Wall-following motion controller: debounced sensors, Moore FSM, timed turns, stuck detect.
module wall_follower_ctrl
    import wf_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned TURN_CYCLES     = 4,
    parameter int unsigned STUCK_LIMIT     = 3,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       hand_sel,
    input  logic       front_sensor,
    input  logic       left_sensor,
    input  logic       right_sensor,
    output logic       front,
    output logic       turn,
    output logic       turn_dir,
    output logic       stuck,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic front_db, left_db, right_db;
    logic wall;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] turn_cnt, turn_cnt_nxt;
    logic [CNT_W-1:0] blk_cnt, blk_cnt_nxt;
    logic             hand_lat, hand_nxt;
    logic             front_nxt, turn_nxt, turn_dir_nxt, stuck_nxt;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_front (
        .clk(clk), .reset(reset), .raw(front_sensor), .clean(front_db)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
        .clk(clk), .reset(reset), .raw(left_sensor), .clean(left_db)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
        .clk(clk), .reset(reset), .raw(right_sensor), .clean(right_db)
    );

    assign wall = hand_lat ? right_db : left_db;

    // State, counters, hand latch and decoded outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            turn_cnt  <= '0;
            blk_cnt   <= '0;
            hand_lat  <= DIR_LEFT;
            front     <= 1'b0;
            turn      <= 1'b0;
            turn_dir  <= 1'b0;
            stuck     <= 1'b0;
            state_dbg <= 3'd0;
        end else begin
            state     <= state_nxt;
            turn_cnt  <= turn_cnt_nxt;
            blk_cnt   <= blk_cnt_nxt;
            hand_lat  <= hand_nxt;
            front     <= front_nxt;
            turn      <= turn_nxt;
            turn_dir  <= turn_dir_nxt;
            stuck     <= stuck_nxt;
            state_dbg <= state_nxt;
        end
    end

    // Next-state, counter updates and Moore decode of the state being entered
    always_comb begin
        state_nxt    = state;
        turn_cnt_nxt = turn_cnt;
        blk_cnt_nxt  = blk_cnt;
        hand_nxt     = hand_lat;
        front_nxt    = 1'b0;
        turn_nxt     = 1'b0;
        turn_dir_nxt = 1'b0;
        stuck_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SEEK;
                    hand_nxt  = hand_sel;
                end
            end
            SEEK: begin
                if (front_db) begin
                    state_nxt    = TURN_AWAY;
                    turn_cnt_nxt = TURN_LOAD;
                end else if (wall) begin
                    state_nxt = FOLLOW;
                end
            end
            FOLLOW: begin
                if (front_db) begin
                    state_nxt    = TURN_AWAY;
                    turn_cnt_nxt = TURN_LOAD;
                end else if (!wall) begin
                    state_nxt    = TURN_TOWARD;
                    turn_cnt_nxt = TURN_LOAD;
                end
            end
            TURN_AWAY: begin
                if (turn_cnt != '0) begin
                    turn_cnt_nxt = turn_cnt - CNT_ONE;
                end else if (front_db) begin
                    blk_cnt_nxt = blk_cnt + CNT_ONE;
                    if (blk_cnt + CNT_ONE == STUCK_MAX) begin
                        state_nxt = HALT;
                    end else begin
                        turn_cnt_nxt = TURN_LOAD;
                    end
                end else begin
                    state_nxt = wall ? FOLLOW : SEEK;
                end
            end
            TURN_TOWARD: begin
                if (turn_cnt != '0) begin
                    turn_cnt_nxt = turn_cnt - CNT_ONE;
                end else begin
                    state_nxt = SEEK;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Dropping enable wins over every other transition
        if (state != IDLE && !enable) begin
            state_nxt = IDLE;
        end

        if (state_nxt == IDLE || state_nxt == SEEK || state_nxt == FOLLOW) begin
            blk_cnt_nxt = '0;
        end

        case (state_nxt)
            SEEK, FOLLOW: front_nxt = 1'b1;
            TURN_AWAY: begin
                turn_nxt     = 1'b1;
                turn_dir_nxt = ~hand_nxt;
            end
            TURN_TOWARD: begin
                turn_nxt     = 1'b1;
                turn_dir_nxt = hand_nxt;
            end
            HALT:    stuck_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Directed scoreboard bench for wall_follower_ctrl (default parameters).
module tb_wall_follower_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       hand_sel;
    logic       front_sensor;
    logic       left_sensor;
    logic       right_sensor;
    logic       front;
    logic       turn;
    logic       turn_dir;
    logic       stuck;
    logic [2:0] state_dbg;

    // Observed vector: {state_dbg, front, turn, turn_dir, stuck}
    logic [6:0] obs;
    assign obs = {state_dbg, front, turn, turn_dir, stuck};

    localparam logic [6:0] IDL = {3'd0, 4'b0000};
    localparam logic [6:0] SEK = {3'd1, 4'b1000};
    localparam logic [6:0] FOL = {3'd2, 4'b1000};
    localparam logic [6:0] TAL = {3'd3, 4'b0100};
    localparam logic [6:0] TAR = {3'd3, 4'b0110};
    localparam logic [6:0] TTR = {3'd4, 4'b0110};
    localparam logic [6:0] HLT = {3'd5, 4'b0001};

    int tests  = 0;
    int failed = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    wall_follower_ctrl dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .hand_sel(hand_sel),
        .front_sensor(front_sensor),
        .left_sensor(left_sensor),
        .right_sensor(right_sensor),
        .front(front),
        .turn(turn),
        .turn_dir(turn_dir),
        .stuck(stuck),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [6:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic check_out();
        logic [6:0] e;
        string      t;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $error("FAIL scoreboard_empty: observed %b expected <entry>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                failed++;
                $error("FAIL %s: observed %b expected %b", t, obs, e);
            end
        end
    endtask

    task automatic tick(input string tag, input logic [6:0] e);
        expect_out(tag, e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        hand_sel     = 1'b0;
        front_sensor = 1'b0;
        left_sensor  = 1'b0;
        right_sensor = 1'b0;

        // Reset state
        #3;
        expect_out("reset_state", IDL);
        check_out();
        #4;
        reset  = 1'b0;
        enable = 1'b1;

        // 1: first edge enters SEEK
        tick("t1_seek", SEK);

        // 2: left wall appears, FOLLOW on 4th edge
        left_sensor = 1'b1;
        for (int i = 0; i < 3; i++) tick("t2_seek_db", SEK);
        tick("t2_follow", FOL);
        front_sensor = 1'b1;
        for (int i = 0; i < 3; i++) tick("t2_follow_db", FOL);
        tick("t2_turn_away_0", TAR);
        front_sensor = 1'b0;
        for (int i = 0; i < 3; i++) tick("t2_turn_away_n", TAR);
        tick("t2_back_follow", FOL);

        // 3: short front pulse ignored
        front_sensor = 1'b1;
        tick("t3_pulse_a", FOL);
        tick("t3_pulse_b", FOL);
        front_sensor = 1'b0;
        for (int i = 0; i < 3; i++) tick("t3_pulse_after", FOL);

        // 4: persistent block in SEEK -> three windows then HALT
        enable      = 1'b0;
        left_sensor = 1'b0;
        for (int i = 0; i < 3; i++) tick("t4_idle", IDL);
        enable       = 1'b1;
        front_sensor = 1'b1;
        for (int i = 0; i < 3; i++) tick("t4_seek", SEK);
        for (int i = 0; i < 12; i++) tick("t4_blocked_turn", TAR);
        tick("t4_halt", HLT);
        tick("t4_halt_hold", HLT);
        enable = 1'b0;
        tick("t4_disable", IDL);

        // 5: right-hand following, hand_sel toggle ignored while running
        front_sensor = 1'b0;
        right_sensor = 1'b1;
        for (int i = 0; i < 3; i++) tick("t5_idle", IDL);
        enable   = 1'b1;
        hand_sel = 1'b1;
        tick("t5_seek", SEK);
        tick("t5_follow", FOL);
        hand_sel     = 1'b0;
        right_sensor = 1'b0;
        for (int i = 0; i < 3; i++) tick("t5_follow_db", FOL);
        for (int i = 0; i < 4; i++) tick("t5_turn_toward", TTR);
        tick("t5_seek_after", SEK);
        tick("t5_seek_hold", SEK);

        // 6: async reset mid TURN_AWAY (hand latched right -> away is left)
        front_sensor = 1'b1;
        for (int i = 0; i < 3; i++) tick("t6_seek", SEK);
        tick("t6_turn_away", TAL);
        #2;
        reset = 1'b1;
        #1;
        expect_out("t6_async_reset", IDL);
        check_out();
        #2;
        reset = 1'b0;
        tick("t6_restart_seek", SEK);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/wall_follower_ctrl.md
Name: wall_follower_ctrl

Overview:
Parametrised wall-following motion controller for the maze robot, successor to the two-sensor left-wall FSM. Debounces front/left/right sensors and follows the left or right wall (selectable). Turns last a fixed number of cycles, and the block reports a stuck condition after repeated blocked turns. Sits between the raw sensor inputs and the drive/steer logic.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive stable samples required before a debounced sensor changes (>=1)
TURN_CYCLES, 4, cycles a turn command is held (>=1)
STUCK_LIMIT, 3, consecutive TURN_AWAY windows with front still blocked before HALT (>=1)
CNT_W, 8, counter width; must hold max(DEBOUNCE_CYCLES, TURN_CYCLES, STUCK_LIMIT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; 0 forces IDLE
hand_sel  in  1  0 = follow left wall, 1 = follow right wall; latched on IDLE->SEEK
front_sensor  in  1  raw, 1 = obstacle ahead
left_sensor  in  1  raw, 1 = wall on left
right_sensor  in  1  raw, 1 = wall on right
front  out  1  drive forward
turn  out  1  turn in place
turn_dir  out  1  0 = left, 1 = right; valid when turn=1, else 0
stuck  out  1  controller halted after repeated blocked turns
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async): state=IDLE, all outputs 0, debounced sensors 0, all counters 0, hand latch 0.
- All outputs are registered and decoded from the state register (Moore). An output reflects the state entered at the same edge.
- Debounce per sensor: a counter tracks the cycles where raw != debounced and clears when raw == debounced. The debounced value flips at the edge where the count reaches DEBOUNCE_CYCLES. A raw change held for N cycles flips the debounced value after N edges; shorter pulses are ignored.
- wall = hand_lat ? right_db : left_db. away_dir = ~hand_lat; toward_dir = hand_lat.
- States and encoding:
  - IDLE (0): outputs 0. enable=1 -> SEEK and latch hand_sel.
  - SEEK (1): front=1. front_db -> TURN_AWAY; else wall -> FOLLOW.
  - FOLLOW (2): front=1. front_db -> TURN_AWAY; else !wall -> TURN_TOWARD.
  - TURN_AWAY (3): turn=1, turn_dir=away_dir. Held exactly TURN_CYCLES cycles; the turn counter loads TURN_CYCLES-1 on entry and exits at 0. On exit:
    - front_db still 1: increment blocked count. If blocked count == STUCK_LIMIT -> HALT; else re-enter TURN_AWAY and reload the counter.
    - otherwise: wall -> FOLLOW; else -> SEEK.
  - TURN_TOWARD (4): turn=1, turn_dir=toward_dir for TURN_CYCLES cycles, then -> SEEK.
  - HALT (5): front=turn=0, stuck=1. Leaves only via enable=0.
- Priority in every state except IDLE: enable=0 -> IDLE on the next edge, outputs 0. This overrides all other transitions.
- Blocked count clears on entry to SEEK/FOLLOW, IDLE, and on reset.
- hand_sel changes while running are ignored until the next IDLE->SEEK.
- Sensor changes during a turn do not shorten it. Only front_db at the exit edge is evaluated.
- Reset mid-operation: outputs drop to 0 immediately (asynchronous), with no wait for the clock.
- Unused encodings 6/7 -> IDLE.

Decomposition:
- Shared package wf_pkg: state enum/localparams (IDLE..HALT), direction constants DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module sensor_debounce (params DEBOUNCE_CYCLES, CNT_W; ports clk, reset, raw, clean), instantiated 3x. FSM, turn counter and blocked counter stay in the top.

Test Plan:
1. Reset, enable=1, all sensors 0 -> after 1 edge state_dbg=1, front=1, turn=0, stuck=0.
2. hand_sel=0, left_sensor=1 held -> FOLLOW on the 4th edge (3 debounce + 1). Then front_sensor=1 -> turn=1, turn_dir=1 for exactly 4 cycles; front clears -> FOLLOW, front=1.
3. front_sensor pulse of 2 cycles while in FOLLOW -> no state change, front stays 1.
4. front_sensor held 1 in SEEK -> three 4-cycle TURN_AWAY windows (12 cycles turn=1), then HALT with stuck=1, front=turn=0. enable=0 -> IDLE next edge, stuck=0.
5. hand_sel=1, FOLLOW on right wall, right_sensor drops -> after debounce: TURN_TOWARD, turn_dir=1 for 4 cycles, then SEEK, front=1. Toggling hand_sel mid-run has no effect.
6. reset asserted between edges during TURN_AWAY -> turn=0, state_dbg=0 before the next clock edge. Release with enable=1 -> SEEK.
